stage5: RTL and testbench
=========================

STAGE5 -- requirements
Module: stage5

Interface
REQ-001 Parameter BIAS, default 15: FP16 exponent bias added to exp_final.
REQ-002 Parameter DEPTH, default 2: output FIFO entries; only value 2 is supported.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port in_valid  input  1: upstream normalized result present this cycle.
REQ-006 Port in_ready  output  1: block accepts the input this cycle.
REQ-007 Port sign  input  1: sign of normalized result, 1 = negative.
REQ-008 Port norm_sum  input  11: normalized significand; bit 10 is the hidden one, value = norm_sum/2^10.
REQ-009 Port exp_final  input  7 signed: unbiased exponent; result = (-1)^sign * norm_sum/2^10 * 2^exp_final.
REQ-010 Port out_valid  output  1: out_fp16 holds a valid packed result.
REQ-011 Port out_ready  input  1: downstream consumes out_fp16 this cycle.
REQ-012 Port out_fp16  output  16: IEEE-754 binary16 {sign, exp[4:0], mant[9:0]}.
REQ-013 Port flag_clr  input  1: clears both sticky flags.
REQ-014 Port ovf_flag  output  1: sticky, set when any accepted result saturated to infinity.
REQ-015 Port udf_flag  output  1: sticky, set when any accepted nonzero result flushed to zero.

Function
REQ-016 A transfer in occurs when in_valid and in_ready are both 1 at a rising edge; a transfer out occurs when out_valid and out_ready are both 1.
REQ-017 in_ready is 1 when FIFO count < 2 and 0 when count == 2, regardless of out_ready (no same-cycle pass-through when full).
REQ-018 out_valid is 1 when count > 0; out_fp16 always shows the head entry, and holds it stable while out_valid=1 and out_ready=0.
REQ-019 Latency: a result accepted at edge N into an empty FIFO appears on out_fp16 with out_valid=1 after edge N (one cycle).
REQ-020 Packing is combinational on accepted inputs, using 8-bit signed arithmetic: e = exp_final + BIAS.
REQ-021 Zero: norm_sum[10]==0 -> {sign, 5'd0, 10'd0}; no flag is set.
REQ-022 Normal: 1 <= e <= 30 -> {sign, e[4:0], norm_sum[9:0]}.
REQ-023 Overflow: e >= 31 -> {sign, 5'h1F, 10'd0} (signed infinity); ovf_flag is set.
REQ-024 Underflow: e <= 0 -> {sign, 5'd0, 10'd0} (flush to zero, no denormals); udf_flag is set.
REQ-025 Simultaneous push and pop with count==1: count stays 1, the new entry becomes head after the pop, and order is preserved.
REQ-026 A pop with count==0 is impossible because out_valid=0; a push with count==2 is impossible because in_ready=0.
REQ-027 FIFO order is strictly first-in-first-out; write and read pointers are 1 bit each and wrap 1 -> 0.
REQ-028 Flags: when flag_clr and a setting event occur in the same cycle, set wins; otherwise flag_clr forces the flag to 0 at the next edge.
REQ-029 Flags update only on accepted transfers; a result held at the input while in_ready=0 does not set any flag.

Reset
REQ-030 While rst=1: count=0, pointers=0, out_valid=0, in_ready=0, ovf_flag=0, udf_flag=0, out_fp16=16'h0000.
REQ-031 Asserting rst mid-operation discards all FIFO contents immediately, without waiting for a clock edge.
REQ-032 in_ready rises in the first cycle after rst deasserts.

Structure
REQ-033 A shared package holds the constants FP16_BIAS=15, FP16_EXP_MAX=31 and the packed-FP16 field widths (1/5/10).
REQ-034 Packing is one combinational sub-module, fp16_pack (inputs sign, norm_sum, exp_final; outputs fp16, ovf, udf); stage5 instantiates it and contains the FIFO, the handshake and the flags.

Verification
REQ-035 Packing checks with out_ready=1, one input per cycle:
  - sign=0, norm_sum=11'h400, exp_final=0 -> out_fp16=16'h3C00 one cycle later; no flags.
  - sign=1, norm_sum=11'h600, exp_final=1 -> 16'hC200.
  - exp_final=15, norm_sum=11'h7FF, sign=0 -> 16'h7BFF.
REQ-036 sign=0, norm_sum=11'h400, exp_final=16 -> 16'h7C00 and ovf_flag=1; pulse flag_clr the following cycle -> ovf_flag=0.
REQ-037 sign=1, norm_sum=11'h500, exp_final=-15 -> 16'h8000 and udf_flag=1; norm_sum=0 -> 16'h0000 with udf_flag unchanged.
REQ-038 Backpressure sequence:
  - Hold out_ready=0 and push A=3C00, B=4000; in_ready=0 after the second push and out_fp16 stays 3C00.
  - Raise out_ready; outputs are A then B in order.
  - A simultaneous push/pop at count==1 keeps count at 1.
REQ-039 Assert rst asynchronously with count==2 -> out_valid=0 immediately; after release no stale entries appear and in_ready=1 the next cycle.

Source files
------------

// File: rtl/stage5_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stage5_pkg
// Brief    : Shared FP16 constants and the packed binary16 layout.
// Revision : 1.0
// ============================================================================
package stage5_pkg;

    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;
    localparam int FP16_SIGN_W  = 1;
    localparam int FP16_EXP_W   = 5;
    localparam int FP16_MANT_W  = 10;
    localparam int FP16_W       = FP16_SIGN_W + FP16_EXP_W + FP16_MANT_W;

    typedef struct packed {
        logic [FP16_SIGN_W-1:0] sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_MANT_W-1:0] mant;
    } fp16_t;

endpackage
`default_nettype wire

// File: rtl/stage5_fp16_pack.sv
`default_nettype none
// ============================================================================
// Module   : fp16_pack
// Brief    : Combinational packer from normalized sign/significand/exponent
//            to IEEE-754 binary16, saturating to infinity or flushing to zero.
// Revision : 1.0
// ============================================================================
module fp16_pack
    import stage5_pkg::*;
#(
    parameter int BIAS = FP16_BIAS
) (
    input  logic              sign,
    input  logic [10:0]       norm_sum,
    input  logic signed [6:0] exp_final,
    output logic [15:0]       fp16,
    output logic              ovf,
    output logic              udf
);

    localparam logic signed [7:0] c_exp_max = 8'(FP16_EXP_MAX);
    localparam logic signed [7:0] c_bias    = 8'(BIAS);

    logic signed [7:0] w_e;
    fp16_t             w_res;

    assign w_e = {exp_final[6], exp_final} + c_bias;

    always_comb begin
        w_res.sign = sign;
        w_res.exp  = '0;
        w_res.mant = '0;
        ovf        = 1'b0;
        udf        = 1'b0;
        // A clear hidden bit means an exact zero, which is never a flush.
        if (!norm_sum[10]) begin
            udf = 1'b0;
        end else if (w_e >= c_exp_max) begin
            w_res.exp = '1;
            ovf       = 1'b1;
        end else if (w_e <= 8'sd0) begin
            udf = 1'b1;
        end else begin
            w_res.exp  = w_e[FP16_EXP_W-1:0];
            w_res.mant = norm_sum[FP16_MANT_W-1:0];
        end
    end

    assign fp16 = w_res;

endmodule
`default_nettype wire

// File: rtl/stage5.sv
`default_nettype none
// ============================================================================
// Module   : stage5
// Brief    : FP16 pack stage with a two-entry output FIFO, valid/ready
//            handshakes and sticky overflow/underflow flags.
// Revision : 1.0
// ============================================================================
module stage5
    import stage5_pkg::*;
#(
    parameter int BIAS  = FP16_BIAS,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign,
    input  logic [10:0]       norm_sum,
    input  logic signed [6:0] exp_final,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_fp16,
    input  logic              flag_clr,
    output logic              ovf_flag,
    output logic              udf_flag
);

    localparam logic [1:0] c_full = 2'(DEPTH);

    logic [15:0] w_pack_fp16;
    logic        w_pack_ovf;
    logic        w_pack_udf;
    logic        w_push;
    logic        w_pop;

    logic [1:0]  r_count;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [15:0] r_mem [0:1];

    fp16_pack #(
        .BIAS      (BIAS)
    ) u_pack (
        .sign      (sign),
        .norm_sum  (norm_sum),
        .exp_final (exp_final),
        .fp16      (w_pack_fp16),
        .ovf       (w_pack_ovf),
        .udf       (w_pack_udf)
    );

    // Held low during reset so nothing is accepted until rst releases.
    assign in_ready  = !rst && (r_count != c_full);
    assign out_valid = (r_count != 2'd0);
    assign out_fp16  = r_mem[r_rd_ptr];
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_pack_fp16;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set has priority over clear when both land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_flag <= 1'b0;
            udf_flag <= 1'b0;
        end else begin
            if (w_push && w_pack_ovf) begin
                ovf_flag <= 1'b1;
            end else if (flag_clr) begin
                ovf_flag <= 1'b0;
            end
            if (w_push && w_pack_udf) begin
                udf_flag <= 1'b1;
            end else if (flag_clr) begin
                udf_flag <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage5.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage5
// Brief    : Directed self-checking bench for stage5 with an output scoreboard.
// Revision : 1.0
// ============================================================================
module tb_stage5;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              sign;
    logic [10:0]       norm_sum;
    logic signed [6:0] exp_final;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_fp16;
    logic              flag_clr;
    logic              ovf_flag;
    logic              udf_flag;

    int          n_checks;
    int          n_fail;
    logic [15:0] sb_q [$];

    stage5 #(
        .BIAS      (15),
        .DEPTH     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign      (sign),
        .norm_sum  (norm_sum),
        .exp_final (exp_final),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp16  (out_fp16),
        .flag_clr  (flag_clr),
        .ovf_flag  (ovf_flag),
        .udf_flag  (udf_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Drives one transfer starting just after a rising edge; returns #1 after the accepting edge.
    task automatic push(input logic s, input logic [10:0] n, input int e, input logic [15:0] exp_v);
        sign      = s;
        norm_sum  = n;
        exp_final = 7'(e);
        in_valid  = 1'b1;
        chk("in_ready_at_push", {15'd0, in_ready}, 16'd1);
        sb_q.push_back(exp_v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Every handshake-out is compared against the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", out_fp16, 16'hxxxx);
            end else begin
                chk("scoreboard_out", out_fp16, sb_q.pop_front());
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        sign      = 1'b0;
        norm_sum  = 11'd0;
        exp_final = 7'sd0;
        out_ready = 1'b0;
        flag_clr  = 1'b0;
        #2;
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_in_ready",  {15'd0, in_ready},  16'd0);
        chk("rst_ovf",       {15'd0, ovf_flag},  16'd0);
        chk("rst_udf",       {15'd0, udf_flag},  16'd0);
        chk("rst_out_fp16",  out_fp16,           16'h0000);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {15'd0, in_ready}, 16'd1);
        @(posedge clk);
        #1;

        // Packing, one input per cycle with the output always draining.
        out_ready = 1'b1;
        push(1'b0, 11'h400, 0, 16'h3C00);
        chk("latency_valid", {15'd0, out_valid}, 16'd1);
        chk("latency_data",  out_fp16,           16'h3C00);
        push(1'b1, 11'h600, 1, 16'hC200);
        push(1'b0, 11'h7FF, 15, 16'h7BFF);
        push(1'b0, 11'h400, -14, 16'h0400);
        chk("normal_no_ovf", {15'd0, ovf_flag}, 16'd0);
        chk("normal_no_udf", {15'd0, udf_flag}, 16'd0);

        push(1'b0, 11'h400, 16, 16'h7C00);
        chk("ovf_set", {15'd0, ovf_flag}, 16'd1);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        chk("ovf_cleared", {15'd0, ovf_flag}, 16'd0);

        push(1'b1, 11'h500, -15, 16'h8000);
        chk("udf_set", {15'd0, udf_flag}, 16'd1);
        push(1'b0, 11'h000, 0, 16'h0000);
        chk("zero_udf_held", {15'd0, udf_flag}, 16'd1);
        chk("zero_no_ovf",   {15'd0, ovf_flag}, 16'd0);

        flag_clr = 1'b1;
        push(1'b1, 11'h400, 20, 16'hFC00);
        chk("set_beats_clr", {15'd0, ovf_flag}, 16'd1);
        chk("clr_udf",       {15'd0, udf_flag}, 16'd0);
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        chk("clr_ovf", {15'd0, ovf_flag}, 16'd0);

        // Backpressure: fill, hold, then drain in order.
        out_ready = 1'b0;
        push(1'b0, 11'h400, 0, 16'h3C00);
        push(1'b0, 11'h400, 1, 16'h4000);
        chk("full_in_ready", {15'd0, in_ready}, 16'd0);
        chk("full_head",     out_fp16,          16'h3C00);
        sign      = 1'b0;
        norm_sum  = 11'h400;
        exp_final = 7'sd16;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("blocked_no_ovf", {15'd0, ovf_flag},  16'd0);
        chk("held_head",      out_fp16,           16'h3C00);
        chk("held_valid",     {15'd0, out_valid}, 16'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        push(1'b1, 11'h600, 1, 16'hC200);
        chk("pushpop_valid", {15'd0, out_valid}, 16'd1);
        chk("pushpop_ready", {15'd0, in_ready},  16'd1);
        chk("pushpop_head",  out_fp16,           16'hC200);
        @(posedge clk);
        #1;
        chk("drained_valid", {15'd0, out_valid}, 16'd0);

        // Asynchronous reset with a full FIFO.
        out_ready = 1'b0;
        push(1'b0, 11'h400, 0, 16'h3C00);
        push(1'b0, 11'h400, 1, 16'h4000);
        #2;
        rst = 1'b1;
        #1;
        sb_q.delete();
        chk("async_rst_valid", {15'd0, out_valid}, 16'd0);
        chk("async_rst_ready", {15'd0, in_ready},  16'd0);
        chk("async_rst_data",  out_fp16,           16'h0000);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rel_in_ready",  {15'd0, in_ready},  16'd1);
        chk("rel_out_valid", {15'd0, out_valid}, 16'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("no_stale_valid", {15'd0, out_valid}, 16'd0);
        push(1'b0, 11'h7FF, 15, 16'h7BFF);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("sb_empty", 16'(sb_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
